// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter: state encoding,
// default priority order and the rotation rule applied after a service.
package dma_arb_pkg;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ORDER_W = NUM_CH * CH_W;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        WAIT_HLDA = 4'b0010,
        GRANT     = 4'b0100,
        RELEASE   = 4'b1000
    } arbState_t;

    localparam logic [ORDER_W-1:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

    // The served channel drops to lowest priority; the one after it becomes highest.
    function automatic logic [ORDER_W-1:0] rotateOrder(input logic [CH_W-1:0] winner);
        logic [ORDER_W-1:0] order;
        for (int i = 0; i < NUM_CH; i++) begin
            order[i*CH_W +: CH_W] = winner + CH_W'(i + 1);
        end
        return order;
    endfunction

endpackage

// File: rtl/dma_priority_select.sv
// Combinational priority pick: the first channel in priorityOrder (lowest
// field first) whose effective request is set.
module dma_priority_select
    import dma_arb_pkg::*;
(
    input  logic [NUM_CH-1:0]  effReq,
    input  logic [ORDER_W-1:0] priorityOrder,
    output logic               found,
    output logic [CH_W-1:0]    winner
);

    // Scanning from lowest priority upward lets the highest-priority hit win last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (effReq[priorityOrder[i*CH_W +: CH_W]]) begin
                found  = 1'b1;
                winner = priorityOrder[i*CH_W +: CH_W];
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DREQ arbitration and HRQ/HLDA bus-hold handshake for the 4-channel DMA
// controller; reports the owning channel to timing control and drives DACK.
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int RELEASE_CYC = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_CH-1:0]  DREQ,
    input  logic [NUM_CH-1:0]  maskReg,
    input  logic               priorityType,
    input  logic               controllerDis,
    input  logic               HLDA,
    input  logic               assertDACK,
    input  logic               serviceDone,
    output logic               HRQ,
    output logic [NUM_CH-1:0]  DACK,
    output logic               grantValid,
    output logic [CH_W-1:0]    grantCh,
    output logic [ORDER_W-1:0] priorityOrder
);

    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);

    arbState_t          state_q, state_d;
    logic               hrq_q, hrq_d;
    logic               grant_valid_q, grant_valid_d;
    logic [CH_W-1:0]    grant_ch_q, grant_ch_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;

    logic [NUM_CH-1:0]  eff_req;
    logic               sel_found;
    logic [CH_W-1:0]    sel_winner;

    assign eff_req = DREQ & ~maskReg;

    dma_priority_select u_select (
        .effReq        (eff_req),
        .priorityOrder (order_q),
        .found         (sel_found),
        .winner        (sel_winner)
    );

    // NOTE: every *_d gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        hrq_d         = hrq_q;
        grant_valid_d = grant_valid_q;
        grant_ch_d    = grant_ch_q;
        order_d       = order_q;
        rel_cnt_d     = rel_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (|eff_req && !controllerDis) begin
                    state_d = WAIT_HLDA;
                    hrq_d   = 1'b1;
                end
            end
            WAIT_HLDA: begin
                if (HLDA) begin
                    if (sel_found) begin
                        state_d       = GRANT;
                        grant_valid_d = 1'b1;
                        grant_ch_d    = sel_winner;
                    end else begin
                        state_d   = RELEASE;
                        hrq_d     = 1'b0;
                        rel_cnt_d = '0;
                    end
                end
            end
            GRANT: begin
                // serviceDone wins over a simultaneous HLDA fall; only it rotates.
                if (serviceDone || !HLDA) begin
                    state_d       = RELEASE;
                    hrq_d         = 1'b0;
                    grant_valid_d = 1'b0;
                    rel_cnt_d     = '0;
                    if (serviceDone && priorityType) begin
                        order_d = rotateOrder(grant_ch_q);
                    end
                end
            end
            RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    state_d = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                hrq_d         = 1'b0;
                grant_valid_d = 1'b0;
            end
        endcase

        if (!priorityType) begin
            order_d = DEFAULT_PRIORITY_ORDER;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
            order_q       <= DEFAULT_PRIORITY_ORDER;
            rel_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hrq_q         <= hrq_d;
            grant_valid_q <= grant_valid_d;
            grant_ch_q    <= grant_ch_d;
            order_q       <= order_d;
            rel_cnt_q     <= rel_cnt_d;
        end
    end

    // DACK drops in the same cycle HLDA falls, unless serviceDone closes the service.
    always_comb begin
        DACK = '0;
        if (state_q == GRANT && assertDACK && (HLDA || serviceDone)) begin
            DACK = NUM_CH'(1) << grant_ch_q;
        end
    end

    assign HRQ           = hrq_q;
    assign grantValid    = grant_valid_q;
    assign grantCh       = grant_ch_q;
    assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed scenarios plus
// randomized services checked against a transaction-level priority model.
module tb_dma_channel_arbiter;

    localparam logic [7:0] DEF_ORDER = 8'b11_10_01_00;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       controllerDis;
    logic       HLDA;
    logic       assertDACK;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantCh;
    logic [7:0] priorityOrder;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ord[4];

    dma_channel_arbiter #(.RELEASE_CYC(1)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .DREQ          (DREQ),
        .maskReg       (maskReg),
        .priorityType  (priorityType),
        .controllerDis (controllerDis),
        .HLDA          (HLDA),
        .assertDACK    (assertDACK),
        .serviceDone   (serviceDone),
        .HRQ           (HRQ),
        .DACK          (DACK),
        .grantValid    (grantValid),
        .grantCh       (grantCh),
        .priorityOrder (priorityOrder)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model (channel list, highest priority first)
    function automatic void model_default();
        for (int i = 0; i < 4; i++) model_ord[i] = i;
    endfunction

    function automatic void model_rotate(input int w);
        for (int i = 0; i < 4; i++) model_ord[i] = (w + 1 + i) % 4;
    endfunction

    function automatic int model_winner(input logic [3:0] eff);
        for (int i = 0; i < 4; i++) begin
            if (eff[model_ord[i]]) return model_ord[i];
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_packed();
        logic [7:0] p;
        for (int i = 0; i < 4; i++) p[2*i +: 2] = 2'(model_ord[i]);
        return p;
    endfunction

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        DREQ = 4'b0000; maskReg = 4'b0000; priorityType = 1'b0; controllerDis = 1'b0;
        HLDA = 1'b0; assertDACK = 1'b0; serviceDone = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET_N = 1'b0;
        step(); step();
        RESET_N = 1'b1;
        step();
        model_default();
    endtask

    task automatic wait_hrq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (HRQ === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        idle_inputs();
        DREQ = 4'b1111;
        RESET_N = 1'b0;
        step(); step();
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL reset_hrq: got %b want 0", HRQ); end
        n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL reset_dack: got %b want 0000", DACK); end
        n_checks++; if (grantValid !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %b want 0", grantValid); end
        n_checks++; if (grantCh !== 2'd0) begin n_fail++; $display("FAIL reset_gch: got %0d want 0", grantCh); end
        n_checks++; if (priorityOrder !== DEF_ORDER) begin n_fail++; $display("FAIL reset_order: got %b want %b", priorityOrder, DEF_ORDER); end
        RESET_N = 1'b1;
        #1;
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL reset_release_hrq: got %b want 0", HRQ); end
        step();
        n_checks++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL reset_hrq_rise: got %b want 1", HRQ); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        DREQ = 4'b1010;
        step();
        n_checks++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fixed_hrq: got %b want 1", HRQ); end
        HLDA = 1'b1;
        step();
        n_checks++; if (grantValid !== 1'b1) begin n_fail++; $display("FAIL fixed_gv: got %b want 1", grantValid); end
        n_checks++; if (grantCh !== 2'd1) begin n_fail++; $display("FAIL fixed_gch: got %0d want 1", grantCh); end
        assertDACK = 1'b1;
        #1;
        n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL fixed_dack: got %b want 0010", DACK); end
        DREQ = 4'b0001;
        step();
        n_checks++; if (grantCh !== 2'd1) begin n_fail++; $display("FAIL fixed_frozen_gch: got %0d want 1", grantCh); end
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0; assertDACK = 1'b0; DREQ = 4'b0000; HLDA = 1'b0;
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL fixed_release_hrq: got %b want 0", HRQ); end
        n_checks++; if (grantValid !== 1'b0) begin n_fail++; $display("FAIL fixed_release_gv: got %b want 0", grantValid); end
        n_checks++; if (priorityOrder !== DEF_ORDER) begin n_fail++; $display("FAIL fixed_order: got %b want %b", priorityOrder, DEF_ORDER); end
        step();
    endtask

    task automatic test_rotating();
        logic [3:0] exp_seq[4];
        bit ok;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        priorityType = 1'b1;
        DREQ = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_hrq(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rot_hrq_timeout: service %0d got no HRQ", k); end
            HLDA = 1'b1;
            step();
            n_checks++; if (grantCh !== 2'(model_winner(DREQ))) begin n_fail++; $display("FAIL rot_gch: service %0d got %0d want %0d", k, grantCh, model_winner(DREQ)); end
            assertDACK = 1'b1;
            #1;
            n_checks++; if (DACK !== exp_seq[k]) begin n_fail++; $display("FAIL rot_dack: service %0d got %b want %b", k, DACK, exp_seq[k]); end
            serviceDone = 1'b1;
            model_rotate(model_winner(DREQ));
            step();
            serviceDone = 1'b0; HLDA = 1'b0; assertDACK = 1'b0;
            n_checks++; if (priorityOrder !== model_packed()) begin n_fail++; $display("FAIL rot_order: service %0d got %b want %b", k, priorityOrder, model_packed()); end
        end
        n_checks++; if (priorityOrder !== DEF_ORDER) begin n_fail++; $display("FAIL rot_final_order: got %b want %b", priorityOrder, DEF_ORDER); end
        DREQ = 4'b0000;
        step(); step();
    endtask

    task automatic test_mask();
        bit ok;
        do_reset();
        maskReg = 4'b0001;
        DREQ = 4'b0001;
        step(); step(); step(); step();
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL mask_hrq: got %b want 0", HRQ); end
        DREQ = 4'b0011;
        wait_hrq(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mask_hrq_timeout: got no HRQ"); end
        HLDA = 1'b1;
        step();
        n_checks++; if (grantCh !== 2'd1) begin n_fail++; $display("FAIL mask_gch: got %0d want 1", grantCh); end
        assertDACK = 1'b1;
        #1;
        n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL mask_dack: got %b want 0010", DACK); end
        maskReg = 4'b0010;
        step();
        n_checks++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL mask_midgrant_dack: got %b want 0010", DACK); end
        n_checks++; if (grantValid !== 1'b1) begin n_fail++; $display("FAIL mask_midgrant_gv: got %b want 1", grantValid); end
        serviceDone = 1'b1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        priorityType = 1'b1;
        DREQ = 4'b0100;
        wait_hrq(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_hrq_timeout: got no HRQ"); end
        HLDA = 1'b1;
        step();
        n_checks++; if (grantCh !== 2'd2) begin n_fail++; $display("FAIL abort_gch: got %0d want 2", grantCh); end
        assertDACK = 1'b1;
        #1;
        n_checks++; if (DACK !== 4'b0100) begin n_fail++; $display("FAIL abort_dack_before: got %b want 0100", DACK); end
        HLDA = 1'b0;
        #1;
        n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL abort_dack_same_cycle: got %b want 0000", DACK); end
        step();
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL abort_hrq: got %b want 0", HRQ); end
        n_checks++; if (priorityOrder !== DEF_ORDER) begin n_fail++; $display("FAIL abort_order: got %b want %b", priorityOrder, DEF_ORDER); end
        idle_inputs();
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        DREQ = 4'b0001;
        step();
        n_checks++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL withdraw_hrq: got %b want 1", HRQ); end
        DREQ = 4'b0000;
        step();
        HLDA = 1'b1; assertDACK = 1'b1;
        step();
        n_checks++; if (grantValid !== 1'b0) begin n_fail++; $display("FAIL withdraw_gv: got %b want 0", grantValid); end
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL withdraw_hrq_release: got %b want 0", HRQ); end
        n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL withdraw_dack: got %b want 0000", DACK); end
        HLDA = 1'b0; assertDACK = 1'b0;
        step(); step();
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL withdraw_idle_hrq: got %b want 0", HRQ); end
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        do_reset();
        DREQ = 4'b1000;
        wait_hrq(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstgrant_hrq_timeout: got no HRQ"); end
        HLDA = 1'b1;
        step();
        assertDACK = 1'b1;
        #1;
        n_checks++; if (DACK !== 4'b1000) begin n_fail++; $display("FAIL rstgrant_dack: got %b want 1000", DACK); end
        RESET_N = 1'b0;
        #1;
        n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL rstgrant_dack_clear: got %b want 0000", DACK); end
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rstgrant_hrq_clear: got %b want 0", HRQ); end
        n_checks++; if (grantValid !== 1'b0) begin n_fail++; $display("FAIL rstgrant_gv_clear: got %b want 0", grantValid); end
        idle_inputs();
        step();
        RESET_N = 1'b1;
        step();
    endtask

    task automatic test_controller_dis();
        bit ok;
        do_reset();
        controllerDis = 1'b1;
        DREQ = 4'b0001;
        step(); step(); step();
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL dis_hrq: got %b want 0", HRQ); end
        controllerDis = 1'b0;
        wait_hrq(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dis_hrq_timeout: got no HRQ"); end
        HLDA = 1'b1;
        step();
        controllerDis = 1'b1;
        step();
        n_checks++; if (grantValid !== 1'b1) begin n_fail++; $display("FAIL dis_inflight_gv: got %b want 1", grantValid); end
        priorityType = 1'b1;
        serviceDone = 1'b1;
        model_rotate(0);
        step();
        n_checks++; if (priorityOrder !== model_packed()) begin n_fail++; $display("FAIL dis_order: got %b want %b", priorityOrder, model_packed()); end
        n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL dis_done_hrq: got %b want 0", HRQ); end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            logic [3:0] dreq, mask, eff, exp_dack;
            bit pt, ok;
            int w, hold, kind;
            pt = 1'($urandom_range(0, 1));
            priorityType = pt;
            if (!pt) model_default();
            dreq = 4'($urandom_range(0, 15));
            mask = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            DREQ = dreq; maskReg = mask;
            eff = dreq & ~mask;
            if ($urandom_range(0, 7) == 0) begin
                controllerDis = 1'b1;
                step(); step(); step();
                n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rnd_dis_hrq: iter %0d got %b want 0", t, HRQ); end
                controllerDis = 1'b0;
            end
            if (eff == 4'b0000) begin
                step(); step();
                n_checks++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rnd_noreq_hrq: iter %0d got %b want 0", t, HRQ); end
                continue;
            end
            wait_hrq(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_hrq_timeout: iter %0d got no HRQ", t); end
            if (!ok) continue;
            if ($urandom_range(0, 3) == 0) begin
                dreq = 4'($urandom_range(0, 15));
                DREQ = dreq;
                eff = dreq & ~mask;
            end
            w = model_winner(eff);
            HLDA = 1'b1;
            step();
            if (w < 0) begin
                n_checks++; if (grantValid !== 1'b0 || HRQ !== 1'b0) begin n_fail++; $display("FAIL rnd_withdraw: iter %0d gv=%b hrq=%b want 0 0", t, grantValid, HRQ); end
                HLDA = 1'b0; DREQ = 4'b0000;
                step();
                continue;
            end
            n_checks++; if (grantValid !== 1'b1) begin n_fail++; $display("FAIL rnd_gv: iter %0d got %b want 1", t, grantValid); end
            n_checks++; if (grantCh !== 2'(w)) begin n_fail++; $display("FAIL rnd_gch: iter %0d got %0d want %0d (eff %b)", t, grantCh, w, eff); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                assertDACK = 1'($urandom_range(0, 1));
                DREQ = 4'($urandom_range(0, 15));
                maskReg = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) controllerDis = 1'b1;
                exp_dack = assertDACK ? (4'b0001 << w) : 4'b0000;
                #1;
                n_checks++; if (DACK !== exp_dack) begin n_fail++; $display("FAIL rnd_dack: iter %0d got %b want %b", t, DACK, exp_dack); end
                step();
                n_checks++; if (grantCh !== 2'(w)) begin n_fail++; $display("FAIL rnd_gch_hold: iter %0d got %0d want %0d", t, grantCh, w); end
            end
            kind = $urandom_range(0, 2);
            if (kind < 2) begin
                serviceDone = 1'b1;
                if (kind == 1) HLDA = 1'b0;
                if (pt) model_rotate(w);
                step();
                serviceDone = 1'b0;
            end else begin
                assertDACK = 1'b1;
                HLDA = 1'b0;
                #1;
                n_checks++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL rnd_abort_dack: iter %0d got %b want 0000", t, DACK); end
                step();
            end
            HLDA = 1'b0; assertDACK = 1'b0; DREQ = 4'b0000; controllerDis = 1'b0;
            n_checks++; if (HRQ !== 1'b0 || grantValid !== 1'b0) begin n_fail++; $display("FAIL rnd_release: iter %0d hrq=%b gv=%b want 0 0", t, HRQ, grantValid); end
            n_checks++; if (priorityOrder !== model_packed()) begin n_fail++; $display("FAIL rnd_order: iter %0d got %b want %b", t, priorityOrder, model_packed()); end
            step();
        end
    endtask

    initial begin
        model_default();
        test_reset();
        test_fixed_priority();
        test_rotating();
        test_mask();
        test_abort();
        test_withdraw();
        test_reset_mid_grant();
        test_controller_dis();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
